// File: rtl/pu_riscv_du_rf_access.sv
// ---------------------------------------------------------------------------
// pu_riscv_du_rf_access
//
// Debug-unit controller for the integer register file's debug port. A single
// read or write request from the debug transport is latched, the core is
// stalled until the pipeline reports halted, one register-file access is
// performed, and a one-cycle acknowledge (with data or error) is returned.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   dbg_req/we/addr/dati debug transport request (sampled only when idle)
//   dbg_halt             external sticky halt request, ORed into du_stall
//   dbg_ack/err/dato     one-cycle completion pulse, error flag, read data
//   core_halted          pipeline drained and frozen
//   du_stall             stall request to the core
//   du_we_rf             register-file write strobe (one cycle)
//   du_addr/du_dato      register address and write data to the register file
//   du_dati_rf           register-file read data (combinational from du_addr)
// ---------------------------------------------------------------------------
module pu_riscv_du_rf_access #(
  parameter int XLEN    = 64,
  parameter int AR_BITS = 5,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [11:0]     dbg_addr,
  input  logic [XLEN-1:0] dbg_dati,
  input  logic            dbg_halt,
  output logic            dbg_ack,
  output logic            dbg_err,
  output logic [XLEN-1:0] dbg_dato,
  input  logic            core_halted,
  output logic            du_stall,
  output logic            du_we_rf,
  output logic [11:0]     du_addr,
  output logic [XLEN-1:0] du_dato,
  input  logic [XLEN-1:0] du_dati_rf
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    ACCESS,
    ACK
  } state_t;

  state_t            state_q;
  logic              stall_q;
  logic              we_q;
  logic [11:0]       addr_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   dato_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ack_q;
  logic              err_q;
  logic              we_rf_q;

  // Any address bit above the GPR window marks the request as out of range.
  logic req_addr_bad;
  logic req_is_x0;

  assign req_addr_bad = (dbg_addr >> AR_BITS) != 12'd0;
  assign req_is_x0    = addr_q[AR_BITS-1:0] == '0;

  // Control FSM with registered outputs. ack/err/we strobes default low each
  // cycle and are raised only on the transition into the state that owns them,
  // so each is high for exactly one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dato_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      we_rf_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      we_rf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dbg_req) begin
            we_q   <= dbg_we;
            addr_q <= dbg_addr;
            data_q <= dbg_dati;
            if (req_addr_bad) begin
              // Out-of-range register: fail fast without disturbing the core.
              state_q <= ACK;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= STALL;
              stall_q <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        STALL: begin
          // A halted core wins even on the last allowed wait cycle.
          if (core_halted) begin
            state_q <= ACCESS;
            we_rf_q <= we_q & ~req_is_x0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ACCESS: begin
          if (!we_q) begin
            dato_q <= du_dati_rf;
          end
          state_q <= ACK;
          ack_q   <= 1'b1;
        end
        ACK: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign du_stall = dbg_halt | stall_q;
  assign du_we_rf = we_rf_q;
  assign du_addr  = addr_q;
  assign du_dato  = data_q;
  assign dbg_ack  = ack_q;
  assign dbg_err  = err_q;
  assign dbg_dato = dato_q;

endmodule
